// File: rtl/alu_serial_seq_pkg.sv
// alu_serial_seq_pkg: ALUop codes and sequencer state encoding shared by the serial ALU files.
// Rev 1.0
`default_nettype none
package alu_serial_seq_pkg;

  localparam logic [2:0] ALU_MOV  = 3'b000;
  localparam logic [2:0] ALU_NOT  = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_AND  = 3'b101;
  localparam logic [2:0] ALU_XOR  = 3'b110;
  localparam logic [2:0] ALU_RSVD = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage
`default_nettype wire

// File: rtl/alu_serial_seq_if.sv
// alu_serial_seq_if: request/result bundle between the multicycle datapath and the serial ALU.
// Rev 1.0
`default_nettype none
interface alu_serial_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;

  modport master (output start, op, a, b, input busy, done, result, carry, zero);
  modport slave  (input start, op, a, b, output busy, done, result, carry, zero);
endinterface
`default_nettype wire

// File: rtl/alu_serial_seq_slice.sv
// alu_serial_seq_slice: combinational 1-bit ALU slice; for sub, c_in/c_out form a borrow chain.
// Rev 1.0
`default_nettype none
module alu_serial_seq_slice
  import alu_serial_seq_pkg::*;
(
  input  logic       a_i,
  input  logic       b_i,
  input  logic       c_in_i,
  input  logic [2:0] ALUop_i,
  output logic       result_o,
  output logic       c_out_o
);

  always_comb begin
    result_o = 1'b0;
    c_out_o  = 1'b0;
    case (ALUop_i)
      ALU_MOV: result_o = a_i;
      ALU_NOT: result_o = ~a_i;
      ALU_ADD: begin
        result_o = a_i ^ b_i ^ c_in_i;
        c_out_o  = (a_i & b_i) | (c_in_i & (a_i ^ b_i));
      end
      ALU_SUB: begin
        result_o = a_i ^ b_i ^ c_in_i;
        c_out_o  = (~a_i & b_i) | (c_in_i & ~(a_i ^ b_i));
      end
      ALU_OR:  result_o = a_i | b_i;
      ALU_AND: result_o = a_i & b_i;
      ALU_XOR: result_o = a_i ^ b_i;
      default: begin
        result_o = 1'b0;
        c_out_o  = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_serial_seq.sv
// alu_serial_seq: feeds one ALU slice a bit pair per clock (LSB first) to build a WIDTH-bit result.
// Rev 1.0
`default_nettype none
module alu_serial_seq
  import alu_serial_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  alu_serial_seq_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] res_sh_q;
  logic [2:0]       op_q;
  logic             carry_reg_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_q;
  logic             zero_q;

  logic             slice_res_w;
  logic             slice_cout_w;
  logic [WIDTH-1:0] res_sh_d;

  alu_serial_seq_slice u_slice (
    .a_i      (a_sh_q[0]),
    .b_i      (b_sh_q[0]),
    .c_in_i   (carry_reg_q),
    .ALUop_i  (op_q),
    .result_o (slice_res_w),
    .c_out_o  (slice_cout_w)
  );

  // Result bits enter at the MSB, so after WIDTH shifts bit 0 holds the LSB result.
  assign res_sh_d = {slice_res_w, res_sh_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      res_sh_q    <= '0;
      op_q        <= ALU_MOV;
      carry_reg_q <= 1'b0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            a_sh_q      <= bus.a;
            b_sh_q      <= bus.b;
            op_q        <= bus.op;
            res_sh_q    <= '0;
            carry_reg_q <= 1'b0;
            cnt_q       <= '0;
            busy_q      <= 1'b1;
            state_q     <= S_RUN;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          res_sh_q    <= res_sh_d;
          carry_reg_q <= slice_cout_w;
          a_sh_q      <= a_sh_q >> 1;
          b_sh_q      <= b_sh_q >> 1;
          cnt_q       <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            if (op_q == ALU_RSVD) begin
              result_q <= '0;
              carry_q  <= 1'b0;
              zero_q   <= 1'b1;
            end else begin
              result_q <= res_sh_d;
              carry_q  <= ((op_q == ALU_ADD) || (op_q == ALU_SUB)) ? slice_cout_w : 1'b0;
              zero_q   <= (res_sh_d == '0);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.carry  = carry_q;
  assign bus.zero   = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_serial_seq.sv
// tb_alu_serial_seq: directed-vector bench for the 8-bit serial ALU sequencer.
// Rev 1.0
`default_nettype none
module tb_alu_serial_seq;

  localparam int WIDTH = 8;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  alu_serial_seq_if #(.WIDTH(WIDTH)) bus ();

  alu_serial_seq #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Accepts one op, then scrambles the inputs to show they are not re-read.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] exp_res,
                       input logic exp_c, input logic exp_z);
    int cycles;
    int busy_cnt;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = ~a;
    bus.b     = ~b;
    bus.op    = 3'b101;
    cycles    = 0;
    busy_cnt  = 0;
    while (!bus.done && cycles < 20) begin
      if (bus.busy) busy_cnt++;
      @(negedge clk);
      cycles++;
    end
    chk({tag, ".latency"}, cycles, 8);
    chk({tag, ".busy"}, busy_cnt, 8);
    chk({tag, ".result"}, bus.result, exp_res);
    chk({tag, ".carry"}, bus.carry, exp_c);
    chk({tag, ".zero"}, bus.zero, exp_z);
    @(negedge clk);
    chk({tag, ".done_pulse"}, bus.done, 1'b0);
    chk({tag, ".hold"}, bus.result, exp_res);
  endtask

  initial begin
    int cycles;
    int gap;
    int done_seen;
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(negedge clk);
    chk("reset.busy", bus.busy, 1'b0);
    chk("reset.done", bus.done, 1'b0);
    chk("reset.result", bus.result, 8'h00);
    chk("reset.carry", bus.carry, 1'b0);
    chk("reset.zero", bus.zero, 1'b0);
    rst = 1'b0;

    do_op("add_ovf",  3'b010, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1);
    do_op("sub_brw",  3'b011, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
    do_op("sub_pos",  3'b011, 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
    do_op("xor",      3'b110, 8'hA5, 8'h0F, 8'hAA, 1'b0, 1'b0);
    do_op("and",      3'b101, 8'hA5, 8'h0F, 8'h05, 1'b0, 1'b0);
    do_op("or",       3'b100, 8'hA5, 8'h0F, 8'hAF, 1'b0, 1'b0);
    do_op("not",      3'b001, 8'hA5, 8'h0F, 8'h5A, 1'b0, 1'b0);
    do_op("mov",      3'b000, 8'hA5, 8'h0F, 8'hA5, 1'b0, 1'b0);
    do_op("rsvd",     3'b111, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1);
    do_op("add_carry_in", 3'b010, 8'h7F, 8'h81, 8'h00, 1'b1, 1'b1);

    // start pulsed mid-RUN with different operands must be ignored
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b010; bus.a = 8'h10; bus.b = 8'h20;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b011; bus.a = 8'h01; bus.b = 8'h05;
    @(negedge clk);
    bus.start = 1'b0;
    cycles = 0;
    while (!bus.done && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    chk("midrun.latency", cycles, 5);
    chk("midrun.result", bus.result, 8'h30);
    chk("midrun.carry", bus.carry, 1'b0);

    // back-to-back: start asserted during the DONE cycle
    bus.start = 1'b1; bus.op = 3'b110; bus.a = 8'hA5; bus.b = 8'hFF;
    @(negedge clk);
    bus.start = 1'b0;
    gap = 1;
    while (!bus.done && gap < 20) begin
      @(negedge clk);
      gap++;
    end
    chk("b2b.gap", gap, 9);
    chk("b2b.result", bus.result, 8'h5A);
    chk("b2b.zero", bus.zero, 1'b0);

    // reset during the 4th RUN cycle; prior result is non-zero
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b010; bus.a = 8'h01; bus.b = 8'h01;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mid.busy_before", bus.busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid.busy", bus.busy, 1'b0);
    chk("rst_mid.done", bus.done, 1'b0);
    chk("rst_mid.result", bus.result, 8'h00);
    chk("rst_mid.carry", bus.carry, 1'b0);
    chk("rst_mid.zero", bus.zero, 1'b0);
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) done_seen = 1;
    end
    chk("rst_mid.no_done", done_seen, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
